// File: rtl/etnsoc_csr_xbar.sv
// etnsoc_csr_xbar: one Avalon-MM CSR master fanned out to N_CH CSR windows.
// The upper address bits select the window and one transaction is in flight at a time.
// Every access completes: unmapped windows, and (optionally) stalled slaves,
// return DEAD_VALUE instead of hanging the SoC bus.
// Optional feature: define ETNSOC_CSR_TIMEOUT_EN to abort slave accesses after TIMEOUT_CYC cycles.
module etnsoc_csr_xbar #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 13,
    parameter int                SUB_AW      = 10,
    parameter int                N_CH        = 4,
    parameter logic [DATA_W-1:0] DEAD_VALUE  = DATA_W'(32'hDEAD_BEEF),
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        m_address,
    input  logic                     m_read,
    input  logic                     m_write,
    input  logic [DATA_W-1:0]        m_writedata,
    input  logic [DATA_W/8-1:0]      m_byteenable,
    input  logic                     m_burstcount,
    input  logic                     m_debugaccess,
    output logic                     m_waitrequest,
    output logic [DATA_W-1:0]        m_readdata,
    output logic                     m_readdatavalid,
    output logic [N_CH*SUB_AW-1:0]   s_address,
    output logic [N_CH-1:0]          s_read,
    output logic [N_CH-1:0]          s_write,
    output logic [DATA_W-1:0]        s_writedata,
    output logic [DATA_W/8-1:0]      s_byteenable,
    input  logic [N_CH-1:0]          s_waitrequest,
    input  logic [N_CH*DATA_W-1:0]   s_readdata,
    input  logic [N_CH-1:0]          s_readdatavalid,
    output logic                     err_unmapped,
    output logic                     err_timeout
);

    localparam int BE_W = DATA_W / 8;
    localparam int CH_W = ADDR_W - SUB_AW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_RWAIT,
        S_ACK,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_waitreq;

    logic [SUB_AW-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic                r_isRead;
    logic [CH_W-1:0]     r_ch;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_unmapped;

    logic                w_req;
    logic [CH_W-1:0]     w_reqIdx;
    logic                w_reqMapped;
    logic [N_CH-1:0]     w_chSel;
    logic                w_selWait;
    logic                w_selRdv;
    logic [DATA_W-1:0]   w_selRdata;
    logic                w_tmoFire;

    // The burst and debug qualifiers carry no meaning for single-beat CSR access.
    logic                w_unused;
    assign w_unused = &{1'b0, m_burstcount, m_debugaccess};

    assign w_req       = m_read | m_write;
    assign w_reqIdx    = m_address[ADDR_W-1:SUB_AW];
    assign w_reqMapped = (int'(w_reqIdx) < N_CH);

    // One-hot decode of the latched channel and selection of its response signals.
    always_comb begin
        w_chSel    = '0;
        w_selRdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_chSel[i] = (int'(r_ch) == i);
            if (int'(r_ch) == i) begin
                w_selRdata = s_readdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_selWait = |(s_waitrequest & w_chSel);
    assign w_selRdv  = |(s_readdatavalid & w_chSel);

`ifdef ETNSOC_CSR_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0]    r_tmoCnt;
    logic                r_timedOut;

    // The counter reaches TIMEOUT_CYC on the edge that leaves FWD/RWAIT, so the slave
    // gets exactly TIMEOUT_CYC cycles; a response in that last cycle still wins.
    assign w_tmoFire = (r_tmoCnt == TMO_W'(TIMEOUT_CYC - 1)) &&
                       (((r_state == S_FWD) && w_selWait) ||
                        ((r_state == S_RWAIT) && !w_selRdv));

    // Stall counter restarts on every forwarded access and remembers whether it expired.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmoCnt   <= '0;
            r_timedOut <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_tmoCnt   <= '0;
                r_timedOut <= 1'b0;
            end else if ((r_state == S_FWD) || (r_state == S_RWAIT)) begin
                r_tmoCnt <= r_tmoCnt + 1'b1;
                if (w_tmoFire) begin
                    r_timedOut <= 1'b1;
                end
            end
        end
    end

    assign err_timeout = (r_state == S_ACK) && r_timedOut;
`else
    localparam int UNUSED_TMO = TIMEOUT_CYC;

    assign w_tmoFire   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register; the master stall is registered and released only for the ACK cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_waitreq <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_waitreq <= (w_nextState != S_ACK);
        end
    end

    // Next-state decode: a slave response always takes priority over a timeout.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_nextState = w_reqMapped ? S_FWD : S_ACK;
                end
            end
            S_FWD: begin
                if (!w_selWait) begin
                    w_nextState = r_isRead ? S_RWAIT : S_ACK;
                end else if (w_tmoFire) begin
                    w_nextState = S_ACK;
                end
            end
            S_RWAIT: begin
                if (w_selRdv || w_tmoFire) begin
                    w_nextState = S_ACK;
                end
            end
            S_ACK: begin
                w_nextState = r_isRead ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Command latch and read-data capture; read data is preloaded with DEAD_VALUE so any
    // access that never gets a slave response answers with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_isRead   <= 1'b0;
            r_ch       <= '0;
            r_rdata    <= '0;
            r_unmapped <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_req) begin
                r_addr     <= m_address[SUB_AW-1:0];
                r_wdata    <= m_writedata;
                r_be       <= m_byteenable;
                r_isRead   <= m_read;
                r_ch       <= w_reqIdx;
                r_rdata    <= DEAD_VALUE;
                r_unmapped <= !w_reqMapped;
            end else if ((r_state == S_RWAIT) && w_selRdv) begin
                r_rdata <= w_selRdata;
            end
        end
    end

    // Slave strobes and master response are pure decodes of the registered state.
    always_comb begin
        s_read          = '0;
        s_write         = '0;
        s_address       = '0;
        if (r_state == S_FWD) begin
            s_read  = r_isRead ? w_chSel : '0;
            s_write = r_isRead ? '0 : w_chSel;
            for (int i = 0; i < N_CH; i++) begin
                if (w_chSel[i]) begin
                    s_address[i*SUB_AW +: SUB_AW] = r_addr;
                end
            end
        end
        m_readdatavalid = (r_state == S_RESP);
        m_readdata      = (r_state == S_RESP) ? r_rdata : '0;
        err_unmapped    = (r_state == S_ACK) && r_unmapped;
    end

    assign m_waitrequest = r_waitreq;
    assign s_writedata   = r_wdata;
    assign s_byteenable  = r_be;

endmodule

// File: tb/tb_etnsoc_csr_xbar.sv
// Self-checking bench for etnsoc_csr_xbar: directed master transactions, a behavioural
// slave per channel, and a monitor that compares DUT outputs against queued expectations.
// Timeout scenarios are included when ETNSOC_CSR_TIMEOUT_EN is defined.
module tb_etnsoc_csr_xbar;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 13;
   localparam int SUB_AW = 10;
   localparam int N_CH   = 4;
   localparam int TMO    = 16;

   logic                   clk;
   logic                   rst;
   logic [ADDR_W-1:0]      m_address;
   logic                   m_read;
   logic                   m_write;
   logic [DATA_W-1:0]      m_writedata;
   logic [3:0]             m_byteenable;
   logic                   m_waitrequest;
   logic [DATA_W-1:0]      m_readdata;
   logic                   m_readdatavalid;
   logic [N_CH*SUB_AW-1:0] s_address;
   logic [N_CH-1:0]        s_read;
   logic [N_CH-1:0]        s_write;
   logic [DATA_W-1:0]      s_writedata;
   logic [3:0]             s_byteenable;
   logic [N_CH-1:0]        s_waitrequest;
   logic [N_CH*DATA_W-1:0] s_readdata;
   logic [N_CH-1:0]        s_readdatavalid;
   logic                   err_unmapped;
   logic                   err_timeout;

   int nChecks = 0;
   int nPass   = 0;
   int rdvSeen = 0;

   logic [83:0] strobeQ[$];
   logic [31:0] rdQ[$];
   logic [7:0]  errQ[$];

   int          stallCnt[N_CH];
   bit          noResp[N_CH];
   bit          pendRdv[N_CH];
   bit          lateRdv[N_CH];
   logic [31:0] slvData[N_CH];

   etnsoc_csr_xbar #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .SUB_AW      (SUB_AW),
      .N_CH        (N_CH),
      .DEAD_VALUE  (32'hDEAD_BEEF),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_byteenable    (m_byteenable),
      .m_burstcount    (1'b1),
      .m_debugaccess   (1'b0),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .m_readdatavalid (m_readdatavalid),
      .s_address       (s_address),
      .s_read          (s_read),
      .s_write         (s_write),
      .s_writedata     (s_writedata),
      .s_byteenable    (s_byteenable),
      .s_waitrequest   (s_waitrequest),
      .s_readdata      (s_readdata),
      .s_readdatavalid (s_readdatavalid),
      .err_unmapped    (err_unmapped),
      .err_timeout     (err_timeout)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the DUT wedges somewhere a bounded wait does not cover
   initial begin
      #300000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Expected slave-side snapshot: {s_read, s_write, s_address, s_writedata, s_byteenable}
   function automatic logic [83:0] mkStrobe(input logic [3:0] rd, input logic [3:0] wr, input int ch,
                                            input logic [9:0] sub, input logic [31:0] wd, input logic [3:0] be);
      logic [39:0] a;
      a = '0;
      a[ch*SUB_AW +: SUB_AW] = sub;
      return {rd, wr, a, wd, be};
   endfunction

   // Drive one master command, count cycles until m_waitrequest drops (request cycle included)
   task automatic applyStimulus(input logic rd, input logic wr, input logic [12:0] addr,
                                input logic [31:0] wd, input logic [3:0] be, input int expCycles);
      int cyc;
      bit done;
      @(negedge clk);
      m_read = rd; m_write = wr; m_address = addr; m_writedata = wd; m_byteenable = be;
      cyc = 1;
      done = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!m_waitrequest) done = 1;
      end
      checkOutput("wait_cycles", 128'(cyc), 128'(expCycles));
      @(posedge clk);
      #1;
      m_read = 0; m_write = 0; m_address = '0; m_writedata = '0; m_byteenable = '0;
      repeat (3) @(negedge clk);
   endtask

   // Behavioural slaves: programmable stall, read data one cycle after accept
   initial begin
      s_waitrequest   = '1;
      s_readdatavalid = '0;
      s_readdata      = '0;
      for (int i = 0; i < N_CH; i++) begin
         stallCnt[i] = 0; noResp[i] = 0; pendRdv[i] = 0; lateRdv[i] = 0; slvData[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < N_CH; i++) begin
            s_readdatavalid[i] = 1'b0;
            if (s_read[i] || s_write[i]) begin
               if (stallCnt[i] > 0) begin
                  s_waitrequest[i] = 1'b1;
                  stallCnt[i]--;
               end else begin
                  s_waitrequest[i] = 1'b0;
                  if (s_read[i] && !noResp[i]) pendRdv[i] = 1;
               end
            end else begin
               s_waitrequest[i] = 1'b1;
               if (pendRdv[i] || lateRdv[i]) begin
                  s_readdatavalid[i] = 1'b1;
                  s_readdata[i*DATA_W +: DATA_W] = slvData[i];
                  pendRdv[i] = 0;
                  lateRdv[i] = 0;
               end
            end
         end
      end
   end

   // Monitor: every strobe cycle, read response and error pulse is matched against its queue
   initial begin
      logic [83:0] e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (|s_read || |s_write) begin
               if (strobeQ.size() == 0) checkOutput("unexpected_strobe", {s_read, s_write}, 0);
               else begin
                  e = strobeQ.pop_front();
                  checkOutput("strobe", {s_read, s_write, s_address, s_writedata, s_byteenable}, e);
               end
            end
            if (m_readdatavalid) begin
               rdvSeen++;
               if (rdQ.size() == 0) checkOutput("unexpected_rdv", m_readdatavalid, 0);
               else checkOutput("readdata", m_readdata, rdQ.pop_front());
            end
            if (err_unmapped || err_timeout) begin
               if (errQ.size() == 0) checkOutput("unexpected_err", {err_unmapped, err_timeout}, 0);
               else checkOutput("err_kind", err_unmapped ? 8'h55 : 8'h54, errQ.pop_front());
            end
         end
      end
   end

   initial begin
      int base;
      rst = 1; m_read = 0; m_write = 0; m_address = '0; m_writedata = '0; m_byteenable = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_waitreq", m_waitrequest, 1);
      checkOutput("rst_rdv", m_readdatavalid, 0);
      checkOutput("rst_rdata", m_readdata, 0);
      checkOutput("rst_strobes", {s_read, s_write}, 0);
      checkOutput("rst_saddr", s_address, 0);
      checkOutput("rst_errs", {err_unmapped, err_timeout}, 0);
      rst = 0;
      repeat (2) @(negedge clk);

      $display("[TB] write ch1 zero-wait");
      stallCnt[1] = 0;
      strobeQ.push_back(mkStrobe(4'b0000, 4'b0010, 1, 10'h005, 32'h1234_5678, 4'hF));
      applyStimulus(0, 1, 13'h0405, 32'h1234_5678, 4'hF, 3);

      $display("[TB] read ch3 with 2-cycle stall");
      stallCnt[3] = 2;
      slvData[3]  = 32'hCAFE_F00D;
      repeat (3) strobeQ.push_back(mkStrobe(4'b1000, 4'b0000, 3, 10'h010, 32'h0, 4'h0));
      rdQ.push_back(32'hCAFE_F00D);
      applyStimulus(1, 0, 13'h0C10, 32'h0, 4'h0, 6);

      $display("[TB] unmapped read and write");
      errQ.push_back(8'h55);
      rdQ.push_back(32'hDEAD_BEEF);
      applyStimulus(1, 0, 13'h1800, 32'h0, 4'h0, 2);
      errQ.push_back(8'h55);
      applyStimulus(0, 1, 13'h1C00, 32'hA5A5_A5A5, 4'hF, 2);

      $display("[TB] read+write together on ch0");
      stallCnt[0] = 0;
      slvData[0]  = 32'h1357_9BDF;
      strobeQ.push_back(mkStrobe(4'b0001, 4'b0000, 0, 10'h033, 32'h55AA_55AA, 4'h3));
      rdQ.push_back(32'h1357_9BDF);
      applyStimulus(1, 1, 13'h0033, 32'h55AA_55AA, 4'h3, 4);

`ifdef ETNSOC_CSR_TIMEOUT_EN
      $display("[TB] ch0 stalls past the timeout");
      stallCnt[0] = 1000;
      repeat (TMO) strobeQ.push_back(mkStrobe(4'b0001, 4'b0000, 0, 10'h001, 32'h0, 4'h0));
      errQ.push_back(8'h54);
      rdQ.push_back(32'hDEAD_BEEF);
      applyStimulus(1, 0, 13'h0001, 32'h0, 4'h0, TMO + 2);
      stallCnt[0] = 0;
      slvData[0]  = 32'hBAD0_BAD0;
      base        = rdvSeen;
      lateRdv[0]  = 1;
      repeat (4) @(negedge clk);
      checkOutput("late_rdv_ignored", 128'(rdvSeen - base), 0);
      slvData[2] = 32'h2222_ABCD;
      strobeQ.push_back(mkStrobe(4'b0100, 4'b0000, 2, 10'h07F, 32'h0, 4'h0));
      rdQ.push_back(32'h2222_ABCD);
      applyStimulus(1, 0, 13'h087F, 32'h0, 4'h0, 4);
`endif

      $display("[TB] reset while waiting for read data");
      noResp[2]   = 1;
      stallCnt[2] = 0;
      slvData[2]  = 32'h0BAD_0BAD;
      strobeQ.push_back(mkStrobe(4'b0100, 4'b0000, 2, 10'h07F, 32'h0, 4'h0));
      @(negedge clk);
      m_read = 1; m_address = 13'h087F;
      @(negedge clk);
      @(negedge clk);
      rst = 1; m_read = 0; m_address = '0;
      @(negedge clk);
      checkOutput("rst_mid_strobes", {s_read, s_write}, 0);
      checkOutput("rst_mid_waitreq", m_waitrequest, 1);
      rst = 0;
      base       = rdvSeen;
      lateRdv[2] = 1;
      repeat (6) @(negedge clk);
      checkOutput("rst_no_rdv", 128'(rdvSeen - base), 0);
      noResp[2] = 0;

      repeat (4) @(negedge clk);
      checkOutput("strobeQ_drained", 128'(strobeQ.size()), 0);
      checkOutput("rdQ_drained", 128'(rdQ.size()), 0);
      checkOutput("errQ_drained", 128'(errQ.size()), 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/etnsoc_csr_xbar.md
Name: etnsoc_csr_xbar

Overview:
- Parametrised successor to the single-window SoC-to-application CSR link: one Avalon-MM CSR master port from the SoC fans out to N_CH application CSR windows.
- Decodes the upper address bits and forwards one transaction at a time.
- Tracks the pending read and always returns a response. Unmapped windows and stalled slaves yield DEAD_VALUE instead of hanging the SoC bus.
- Sits between the SoC lightweight bridge and the application CSR blocks.

Parameters:
- DATA_W, 32, data width of master and all slaves; byteenable width is DATA_W/8.
- ADDR_W, 13, master word-address width.
- SUB_AW, 10, per-window address width; window index = m_address[ADDR_W-1:SUB_AW].
- N_CH, 4, number of mapped windows; must be <= 2**(ADDR_W-SUB_AW) and >= 1.
- DEAD_VALUE, 32'hDEAD_BEEF, read data returned on error.
- TIMEOUT_CYC, 1024, slave stall limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  synchronous reset, active-high
- m_address  in  ADDR_W  master word address
- m_read  in  1  master read request
- m_write  in  1  master write request
- m_writedata  in  DATA_W  master write data
- m_byteenable  in  DATA_W/8  master byte enables
- m_burstcount  in  1  ignored; always single beat
- m_debugaccess  in  1  ignored
- m_waitrequest  out  1  master stall
- m_readdata  out  DATA_W  master read data
- m_readdatavalid  out  1  master read data strobe
- s_address  out  N_CH*SUB_AW  per-channel address
- s_read  out  N_CH  per-channel read strobe
- s_write  out  N_CH  per-channel write strobe
- s_writedata  out  DATA_W  shared write data
- s_byteenable  out  DATA_W/8  shared byte enables
- s_waitrequest  in  N_CH  per-channel stall
- s_readdata  in  N_CH*DATA_W  per-channel read data
- s_readdatavalid  in  N_CH  per-channel read data strobe
- err_unmapped  out  1  one-cycle pulse on an access to an unmapped window
- err_timeout  out  1  one-cycle pulse on a slave timeout

Behaviour:
- Reset: state IDLE; m_waitrequest=1; m_readdatavalid=0; m_readdata=0; all s_read/s_write=0; s_address=0; err pulses=0; timeout counter=0. Reset mid-transaction abandons the transaction: strobes are low from the first cycle after the reset edge, and any late slave readdatavalid is ignored.
- m_waitrequest is registered and is 0 only in ACK.
- FSM states: IDLE, FWD, RWAIT, ACK, RESP.
- IDLE:
  - On (m_read|m_write), latch address, data, byteenable, dir and ch = index.
  - If m_read and m_write are both high, the access is treated as a read.
  - If ch >= N_CH: go to ACK with rdata=DEAD_VALUE; err_unmapped pulses in that ACK cycle.
  - Otherwise go to FWD.
- FWD:
  - Drive s_read[ch] or s_write[ch] from the latched registers; s_address slice ch = latched address[SUB_AW-1:0]. Other channels' strobes stay 0.
  - When s_waitrequest[ch]==0, drop the strobe next cycle. A write goes to ACK; a read goes to RWAIT.
- RWAIT:
  - On s_readdatavalid[ch], capture s_readdata slice ch and go to ACK.
  - s_readdatavalid on any other channel is ignored.
- ACK:
  - m_waitrequest=0 for exactly one cycle; the master command completes.
  - A read goes to RESP; a write goes to IDLE.
- RESP:
  - m_readdatavalid=1 for one cycle with m_readdata = captured data, then go to IDLE.
- Latency: a write to a zero-wait slave takes 3 cycles from request to m_waitrequest low. A read to a slave with readdatavalid the cycle after accept gives m_readdatavalid 5 cycles after request.
- Unmapped write: dropped, no slave strobe, 1-cycle ACK after IDLE.
- One outstanding transaction only; the master is stalled until ACK.

Optional Feature:
- Macro: ETNSOC_CSR_TIMEOUT_EN.
- With the macro defined:
  - A counter of $clog2(TIMEOUT_CYC+1) bits clears on entry to FWD and increments in FWD and RWAIT.
  - When it reaches TIMEOUT_CYC: drop the strobe, go to ACK with rdata=DEAD_VALUE (writes are discarded), and pulse err_timeout in that ACK cycle.
  - A slave response in the same cycle as the timeout takes priority; it is not a timeout.
- Without the macro: no counter; FWD and RWAIT wait indefinitely; err_timeout is tied to 0.

Test Plan:
- Write 0x12345678, be=4'hF, to address 13'h0405 (ch1, sub 0x005), with s_waitrequest[1]=0 → s_write[1] high 1 cycle with s_address slice1=10'h005; m_waitrequest low 3 cycles after request; no other s_write asserted.
- Read address 13'h0C10 (ch3); slave stalls 2 cycles, then returns 0xCAFEF00D 1 cycle after accept → m_readdatavalid=1 with m_readdata=0xCAFEF00D exactly once.
- Read address 13'h1800 (window 6, unmapped) → no slave strobe; err_unmapped pulse; m_readdata=0xDEADBEEF.
- Timeout (macro on, TIMEOUT_CYC=16): s_waitrequest[0] held 1 → strobe dropped after 16 cycles; err_timeout pulse; read returns 0xDEADBEEF. A late s_readdatavalid[0] is ignored, and the next read to ch2 returns ch2 data.
- Assert rst while in RWAIT → next cycle all strobes 0 and m_waitrequest=1; a slave readdatavalid after reset produces no m_readdatavalid.
- m_read and m_write high together to ch0 → treated as a read: s_read[0] asserted, s_write[0] never asserted.
